// File: rtl/lcd_message_sequencer.sv
// lcd_message_sequencer: streams a 32-character, two-line message buffer into the LCD
// driver as clear / line-address / data-word writes, with a per-handshake timeout.
`default_nettype none

module lcd_message_sequencer #(
    parameter logic [7:0]  CLEAR_CMD      = 8'h01,
    parameter logic [7:0]  LINE1_ADDR     = 8'h80,
    parameter logic [7:0]  LINE2_ADDR     = 8'hC0,
    parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
    input  logic        CLOCK_27,
    input  logic        rst,
    input  logic        buf_we_i,
    input  logic [4:0]  buf_addr_i,
    input  logic [7:0]  buf_wdata_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] lcd_data_o,
    output logic        lcd_select_cd_o,
    output logic        lcd_enable_o,
    input  logic        lcd_available_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_STEP = 4'd10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_ACK   = 3'd2,
        WAIT_READY = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t           state_q;
    logic [3:0]       step_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             enable_q;
    logic             select_q;
    logic [31:0]      data_q;

    logic [7:0]       buf_q [32];

    logic [31:0]      word_d;
    logic             sel_d;
    logic [3:0]       idx_d;
    logic [4:0]       base_d;

    // Buffer is locked while a send is in progress; contents are never reset.
    always_ff @(posedge CLOCK_27) begin
        if (buf_we_i && !busy_q) begin
            buf_q[buf_addr_i] <= buf_wdata_i;
        end
    end

    // Steps 2..5 map to word 0..3, steps 7..10 to word 4..7; each word is 4 chars.
    always_comb begin
        word_d = 32'h0;
        sel_d  = 1'b0;
        idx_d  = (step_q < 4'd6) ? (step_q - 4'd2) : (step_q - 4'd3);
        base_d = {idx_d[2:0], 2'b00};
        case (step_q)
            4'd0:    word_d = {24'h0, CLEAR_CMD};
            4'd1:    word_d = {24'h0, LINE1_ADDR};
            4'd6:    word_d = {24'h0, LINE2_ADDR};
            default: begin
                sel_d  = 1'b1;
                word_d = {buf_q[base_d], buf_q[base_d + 5'd1],
                          buf_q[base_d + 5'd2], buf_q[base_d + 5'd3]};
            end
        endcase
    end

    always_ff @(posedge CLOCK_27 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= 4'd0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            enable_q <= 1'b0;
            select_q <= 1'b1;
            data_q   <= 32'h0;
        end else begin
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        step_q  <= 4'd0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    data_q   <= word_d;
                    select_q <= sel_d;
                    if (lcd_available_i) begin
                        enable_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!lcd_available_i) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_READY;
                    end else if (cnt_q == CNT_LAST) begin
                        error_q  <= 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        select_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_READY: begin
                    if (lcd_available_i) begin
                        if (step_q == LAST_STEP) begin
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            select_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            step_q  <= step_q + 4'd1;
                            state_q <= ISSUE;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        error_q  <= 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        select_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign lcd_data_o      = data_q;
    assign lcd_select_cd_o = select_q;
    assign lcd_enable_o    = enable_q;

endmodule

`default_nettype wire
